// File: rtl/in_port_pkg.sv
// Shared types and default sizes for the buffered input-port front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package in_port_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_THRESH = 2;

    // Interrupt request sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } irq_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock circular FIFO with fill count; head entry is presented combinationally.
// Latency: a pushed byte is visible at head on the cycle after its push edge when the FIFO was empty.
// Backpressure: the caller qualifies push with ~full and pop with ~empty; both may happen in one cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // An empty FIFO drives zero rather than a stale entry
    assign head  = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/in_port_fifo.sv
// Input-port front end: buffers producer bytes, shows head on e_port, pulses int_req while data is pending.
// Latency: push-to-e_port 1 edge; push-to-int_req 2 edges. Optional macro IN_PORT_THRESH_EN raises the level to THRESH.
// Backpressure: ext_ready drops while full or in reset; bytes offered while full are dropped and flag overflow.
module in_port_fifo
    import in_port_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int THRESH = DEF_THRESH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        ext_data,
    input  logic                    ext_valid,
    output logic                    ext_ready,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        e_port,
    output logic                    int_req,
    input  logic                    int_ack,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("in_port_fifo: DEPTH must be a power of two and at least 2");
    end
    if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
        $error("in_port_fifo: THRESH must lie in 1..DEPTH");
    end

    logic       full;
    logic       empty;
    logic       do_push;
    logic       do_pop;
    logic       pend;
    irq_state_t state;
    irq_state_t state_nxt;

    assign ext_ready = reset & ~full;
    assign do_push   = ext_valid & ext_ready;
    // A read of an empty port is harmless: nothing moves
    assign do_pop    = rd_en & ~empty;

`ifdef IN_PORT_THRESH_EN
    localparam int LVL = THRESH;
    // A full FIFO always asks for service, even if THRESH is never reached by count alone
    assign pend = (count >= CW'(LVL)) | full;
`else
    localparam int LVL = 1;
    assign pend = (count >= CW'(LVL));
`endif

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (do_push),
        .wr_data (ext_data),
        .pop     (do_pop),
        .head    (e_port),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Sticky drop flag; a new drop in the ack cycle keeps it set
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ext_valid & ~ext_ready) begin
            overflow <= 1'b1;
        end else if (int_ack) begin
            overflow <= 1'b0;
        end
    end

    // Interrupt sequencer state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the single-cycle request pulse
    always_comb begin
        state_nxt = state;
        int_req   = 1'b0;
        case (state)
            IDLE: begin
                if (pend) state_nxt = REQ;
            end
            REQ: begin
                int_req   = 1'b1;
                state_nxt = SERV;
            end
            SERV: begin
                if (int_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
